// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO helpers for the write- and read-side pointer controllers.
// Functions work on 32-bit vectors; callers zero-extend and keep the low bits.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int fifo_depth(input int addr_len);
    return 1 << addr_len;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin_to_gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray_to_bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < PTR_MAX_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter, purely combinational.
// No state, no latency, no backpressure.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/wptr_level_ctrl.sv
// Async-FIFO write-side pointer, full/almost-full/overflow flags and fill level.
// Flags/pointer/level register one cycle after accept; wen_o is combinational.
// Writes are refused while full; optional drop counter under WPTR_DROP_CNT_EN.
module wptr_level_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_LEN     = 8,
  parameter int AFULL_THRESH = 2**ADDR_LEN - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                wincr_i,
  input  logic [ADDR_LEN:0]   r2wptr_sync_i,
  input  logic                wovf_clr_i,
  output logic                wen_o,
  output logic [ADDR_LEN-1:0] fifo_waddr_o,
  output logic [ADDR_LEN:0]   wptr_o,
  output logic                wfull_o,
  output logic                wafull_o,
  output logic                wovf_o,
`ifdef WPTR_DROP_CNT_EN
  output logic [ADDR_LEN:0]   wlevel_o,
  output logic [7:0]          wdrop_cnt_o
`else
  output logic [ADDR_LEN:0]   wlevel_o
`endif
);

  localparam int W     = ADDR_LEN + 1;
  localparam int DEPTH = fifo_depth(ADDR_LEN);
  localparam logic [W-1:0] AFULL_LVL = W'((AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH);

  logic [W-1:0] wbin_q, wbin_d;
  logic [W-1:0] wptr_q, wptr_d;
  logic [W-1:0] wlevel_q, wlevel_d;
  logic [W-1:0] rbin;
  logic         wfull_q, wfull_d;
  logic         wafull_q, wafull_d;
  logic         wovf_q, wovf_d;
  logic         wen, rej;

  gray2bin #(.WIDTH(W)) u_rptr_g2b (
    .gray_i (r2wptr_sync_i),
    .bin_o  (rbin)
  );

  always_comb begin
    wen      = wincr_i & ~wfull_q;
    rej      = wincr_i & wfull_q;
    wbin_d   = wbin_q + W'(wen);
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    // Full when pointers match except the two MSBs, compared in Gray space
    wfull_d  = (wptr_d == {~r2wptr_sync_i[ADDR_LEN:ADDR_LEN-1], r2wptr_sync_i[ADDR_LEN-2:0]});
    wlevel_d = wbin_d - rbin;
    wafull_d = (wlevel_d >= AFULL_LVL);
    wovf_d   = wovf_q;
    if (rej)             wovf_d = 1'b1;
    else if (wovf_clr_i) wovf_d = 1'b0;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

`ifdef WPTR_DROP_CNT_EN
  logic [7:0] wdrop_cnt_q, wdrop_cnt_d;

  // A rejected write in the clearing cycle restarts the count at one
  always_comb begin
    wdrop_cnt_d = wdrop_cnt_q;
    if (rej) begin
      if (wovf_clr_i)                wdrop_cnt_d = 8'd1;
      else if (wdrop_cnt_q != 8'hFF) wdrop_cnt_d = wdrop_cnt_q + 8'd1;
    end else if (wovf_clr_i) begin
      wdrop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wdrop_cnt_q <= 8'd0;
    else         wdrop_cnt_q <= wdrop_cnt_d;
  end

  assign wdrop_cnt_o = wdrop_cnt_q;
`endif

  assign wen_o        = wen;
  assign fifo_waddr_o = wbin_q[ADDR_LEN-1:0];
  assign wptr_o       = wptr_q;
  assign wfull_o      = wfull_q;
  assign wafull_o     = wafull_q;
  assign wovf_o       = wovf_q;
  assign wlevel_o     = wlevel_q;

endmodule

// File: tb/tb_wptr_level_ctrl.sv
// Directed bench for wptr_level_ctrl (ADDR_LEN=3, AFULL_THRESH=6) with a count-based model.
module tb_wptr_level_ctrl;

  localparam int AL = 3;
  localparam int AT = 6;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       wincr_i;
  logic       wovf_clr_i;
  logic [3:0] r2wptr_sync_i;
  logic       wen_o;
  logic [2:0] fifo_waddr_o;
  logic [3:0] wptr_o;
  logic [3:0] wlevel_o;
  logic       wfull_o, wafull_o, wovf_o;
`ifdef WPTR_DROP_CNT_EN
  logic [7:0] wdrop_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  int rd    = 0;

  always #5 wclk = ~wclk;

  function automatic logic [3:0] g4(input int x);
    int v;
    v = x % 16;
    return 4'(v ^ (v >> 1));
  endfunction

  assign r2wptr_sync_i = g4(rd);

  wptr_level_ctrl #(.ADDR_LEN(AL), .AFULL_THRESH(AT)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .wincr_i       (wincr_i),
    .r2wptr_sync_i (r2wptr_sync_i),
    .wovf_clr_i    (wovf_clr_i),
    .wen_o         (wen_o),
    .fifo_waddr_o  (fifo_waddr_o),
    .wptr_o        (wptr_o),
    .wfull_o       (wfull_o),
    .wafull_o      (wafull_o),
    .wovf_o        (wovf_o),
`ifdef WPTR_DROP_CNT_EN
    .wlevel_o      (wlevel_o),
    .wdrop_cnt_o   (wdrop_cnt_o)
`else
    .wlevel_o      (wlevel_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: counts accepted writes, level is writes minus reads modulo 16
  int m_wr    = 0;
  int m_level = 0;
  bit m_full  = 0;
  bit m_afull = 0;
  bit m_ovf   = 0;
  int m_drop  = 0;

  always @(posedge wclk or negedge wrst_n) begin
    bit acc, rej;
    if (!wrst_n) begin
      m_wr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_drop = 0;
    end else begin
      acc = wincr_i && !m_full;
      rej = wincr_i && m_full;
      m_wr    = (m_wr + (acc ? 1 : 0)) % 16;
      m_level = (m_wr - (rd % 16) + 16) % 16;
      m_full  = (m_level == 8);
      m_afull = (m_level >= AT);
      if (rej)             m_ovf = 1;
      else if (wovf_clr_i) m_ovf = 0;
      if (rej)             m_drop = wovf_clr_i ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      else if (wovf_clr_i) m_drop = 0;
    end
  end

  always @(negedge wclk) begin
    if (wrst_n === 1'b1) begin
      chk("cmp_wen",    32'(wen_o),        32'(wincr_i && !m_full));
      chk("cmp_waddr",  32'(fifo_waddr_o), 32'(m_wr % 8));
      chk("cmp_wptr",   32'(wptr_o),       32'(m_wr ^ (m_wr >> 1)));
      chk("cmp_level",  32'(wlevel_o),     32'(m_level));
      chk("cmp_full",   32'(wfull_o),      32'(m_full));
      chk("cmp_afull",  32'(wafull_o),     32'(m_afull));
      chk("cmp_ovf",    32'(wovf_o),       32'(m_ovf));
`ifdef WPTR_DROP_CNT_EN
      chk("cmp_drop",   32'(wdrop_cnt_o),  32'(m_drop));
`endif
    end
  end

  task automatic step(input logic inc, input logic clr);
    wincr_i    = inc;
    wovf_clr_i = clr;
    @(posedge wclk);
    #1;
    wincr_i    = 1'b0;
    wovf_clr_i = 1'b0;
  endtask

  initial begin
    wrst_n     = 1'b0;
    wincr_i    = 1'b0;
    wovf_clr_i = 1'b0;
    repeat (2) @(posedge wclk);
    #2 wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    chk("rst_level", 32'(wlevel_o), 0);
    chk("rst_wptr",  32'(wptr_o),   0);
    chk("rst_full",  32'(wfull_o),  0);
    chk("rst_addr",  32'(fifo_waddr_o), 0);

    // Fill
    repeat (6) step(1, 0);
    chk("fill6_level", 32'(wlevel_o), 6);
    chk("fill6_afull", 32'(wafull_o), 1);
    chk("fill6_full",  32'(wfull_o),  0);
    repeat (2) step(1, 0);
    chk("fill8_full",  32'(wfull_o),  1);
    chk("fill8_wptr",  32'(wptr_o),   32'h0000_000C);
    chk("fill8_addr",  32'(fifo_waddr_o), 0);
    chk("fill8_level", 32'(wlevel_o), 8);

    // Overflow
    wincr_i = 1'b1;
    #1;
    chk("ovf_wen",  32'(wen_o), 0);
    chk("ovf_addr", 32'(fifo_waddr_o), 0);
    @(posedge wclk);
    #1;
    wincr_i = 1'b0;
    chk("ovf_set",   32'(wovf_o), 1);
    chk("ovf_level", 32'(wlevel_o), 8);
    step(1, 1);
    chk("ovf_setwins", 32'(wovf_o), 1);
    step(0, 1);
    chk("ovf_clear", 32'(wovf_o), 0);

    // Drain one read at a time
    rd = 1; step(0, 0);
    chk("drain1_level", 32'(wlevel_o), 7);
    chk("drain1_afull", 32'(wafull_o), 1);
    chk("drain1_full",  32'(wfull_o),  0);
    rd = 2; step(0, 0);
    chk("drain2_level", 32'(wlevel_o), 6);
    chk("drain2_afull", 32'(wafull_o), 1);
    rd = 3; step(0, 0);
    chk("drain3_level", 32'(wlevel_o), 5);
    chk("drain3_afull", 32'(wafull_o), 0);

    // Wrap
    rd = 8; step(0, 0);
    chk("wrap_empty_level", 32'(wlevel_o), 0);
    chk("wrap_empty_full",  32'(wfull_o),  0);
    repeat (7) step(1, 0);
    chk("wrap_addr7", 32'(fifo_waddr_o), 7);
    step(1, 0);
    chk("wrap_addr0", 32'(fifo_waddr_o), 0);
    chk("wrap_full",  32'(wfull_o), 1);
    chk("wrap_wptr",  32'(wptr_o),  0);
    step(1, 0);
    chk("wrap_ovf", 32'(wovf_o), 1);

    // Reset mid-burst
    rd = 12; step(0, 0);
    chk("mid_level4", 32'(wlevel_o), 4);
    repeat (2) step(1, 0);
    chk("mid_wptr", 32'(wptr_o), 3);
    wincr_i = 1'b1;
    #2 wrst_n = 1'b0;
    #1;
    chk("arst_wptr",  32'(wptr_o),       0);
    chk("arst_level", 32'(wlevel_o),     0);
    chk("arst_full",  32'(wfull_o),      0);
    chk("arst_afull", 32'(wafull_o),     0);
    chk("arst_ovf",   32'(wovf_o),       0);
    chk("arst_addr",  32'(fifo_waddr_o), 0);
    wincr_i = 1'b0;
    rd = 0;
    #2 wrst_n = 1'b1;
    wincr_i = 1'b1;
    #1;
    chk("post_rst_wen",  32'(wen_o), 1);
    chk("post_rst_addr", 32'(fifo_waddr_o), 0);
    @(posedge wclk);
    #1;
    wincr_i = 1'b0;
    chk("post_rst_addr1",  32'(fifo_waddr_o), 1);
    chk("post_rst_level1", 32'(wlevel_o), 1);

`ifdef WPTR_DROP_CNT_EN
    repeat (7) step(1, 0);
    chk("drop_full", 32'(wfull_o), 1);
    repeat (300) step(1, 0);
    chk("drop_sat", 32'(wdrop_cnt_o), 255);
    step(1, 1);
    chk("drop_incwins", 32'(wdrop_cnt_o), 1);
    step(0, 1);
    chk("drop_clear", 32'(wdrop_cnt_o), 0);
`endif

    repeat (2) @(posedge wclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wptr_level_ctrl.md
WPTR_LEVEL_CTRL -- requirements
Module: wptr_level_ctrl

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 8: FIFO address width; depth DEPTH = 2**ADDR_LEN; legal ADDR_LEN >= 2.
REQ-002 SHALL have parameter AFULL_THRESH, default 2**ADDR_LEN-2: almost-full level; legal 1..DEPTH.
REQ-003 SHALL have port wclk  input  1  write-domain clock, rising edge.
REQ-004 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wincr_i  input  1  write request.
REQ-006 SHALL have port r2wptr_sync_i  input  ADDR_LEN+1  Gray read pointer, already synchronised to wclk.
REQ-007 SHALL have port wovf_clr_i  input  1  clears sticky overflow.
REQ-008 SHALL have port wen_o  output  1  combinational memory write enable.
REQ-009 SHALL have port fifo_waddr_o  output  ADDR_LEN  memory write address.
REQ-010 SHALL have port wptr_o  output  ADDR_LEN+1  registered Gray write pointer.
REQ-011 SHALL have ports wfull_o, wafull_o, wovf_o  output  1 each; and wlevel_o  output  ADDR_LEN+1  fill level.

Function
REQ-012 SHALL keep an internal binary pointer wbin (ADDR_LEN+1 bits); wen_o = wincr_i & ~wfull_o; wbin_next = wbin + wen_o, modulo 2**(ADDR_LEN+1).
REQ-013 SHALL drive fifo_waddr_o = wbin[ADDR_LEN-1:0]; memory writes at the current address in the same cycle wen_o is high.
REQ-014 SHALL register wptr_o <= (wbin_next>>1) ^ wbin_next each cycle (one-cycle latency from accept).
REQ-015 SHALL register wfull_o <= (gray(wbin_next) == {~r2wptr_sync_i[ADDR_LEN:ADDR_LEN-1], r2wptr_sync_i[ADDR_LEN-2:0]}).
REQ-016 SHALL convert r2wptr_sync_i to binary rbin and register wlevel_o <= wbin_next - rbin (modulo 2**(ADDR_LEN+1); range 0..DEPTH).
REQ-017 SHALL register wafull_o <= (wbin_next - rbin) >= AFULL_THRESH; wafull_o and wfull_o both high at level DEPTH.
REQ-018 SHALL ignore wincr_i while wfull_o = 1: no pointer, address or level change; wen_o = 0.
REQ-019 SHALL register wovf_o: set when wincr_i & wfull_o; cleared by wovf_clr_i; set wins over simultaneous clear; otherwise holds.
REQ-020 SHALL wrap fifo_waddr_o DEPTH-1 -> 0 seamlessly with wbin MSB toggling; wrap causes no flag glitch.
REQ-021 SHALL deassert wfull_o/wafull_o only on the cycle after r2wptr_sync_i advances (pessimistic, never optimistic).

Reset
REQ-022 SHALL on wrst_n low asynchronously force wbin, wptr_o, wlevel_o to 0 and wfull_o, wafull_o, wovf_o to 0; fifo_waddr_o = 0.
REQ-023 SHALL, on reset mid-burst, drop any in-flight request; first accept after release writes address 0.

Configuration
REQ-024 SHALL, with macro WPTR_DROP_CNT_EN defined, add output wdrop_cnt_o (8 bits): counts rejected requests (wincr_i & wfull_o), saturates at 255, cleared by wovf_clr_i (increment wins on simultaneous event: result 1 if cleared), reset 0.
REQ-025 SHALL, without WPTR_DROP_CNT_EN, have no wdrop_cnt_o port and no counter logic; all other behaviour identical.

Structure
REQ-026 SHALL place DEPTH derivation and bin2gray/gray2bin functions in shared package async_fifo_pkg, reused by the read-side controller.
REQ-027 SHALL instantiate one sub-module gray2bin (parametrised width ADDR_LEN+1) for rbin.

Verification (ADDR_LEN=3, AFULL_THRESH=6, r2wptr_sync_i=0 unless stated)
REQ-028 SHALL check reset: assert wrst_n=0 mid-cycle -> all outputs 0 immediately, no clock needed.
REQ-029 SHALL check fill: 6 accepts -> wlevel_o=6, wafull_o=1; 8 accepts -> wfull_o=1 next cycle, wptr_o=4'b1100, fifo_waddr_o=0.
REQ-030 SHALL check overflow: wincr_i while full -> wen_o=0, address held, wovf_o=1 next cycle; wovf_clr_i with simultaneous rejected write -> wovf_o stays 1; clear alone -> 0.
REQ-031 SHALL check wrap: r2wptr_sync_i=4'b1100 (rbin 8) after 8 writes -> wfull_o=0, wlevel_o=0 next cycle; 8 more writes -> address 7->0 wrap, wfull_o=1, wptr_o=4'b0000.
REQ-032 SHALL check drain: full FIFO, r2wptr_sync_i steps gray(1), gray(2), gray(3) -> wlevel_o 7,6,5 and wafull_o drops to 0 at level 5.
REQ-033 SHALL check WPTR_DROP_CNT_EN build: 300 rejected writes -> wdrop_cnt_o=255; clear -> 0.
